uart_framed: RTL and testbench

UART_FRAMED -- requirements
Module: uart_framed

---
 rtl/uart_framed.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_framed.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_framed.sv
// rtl/uart_framed.sv - UART with RX/TX FIFOs, optional parity, configurable stop bits
// and sticky RX error flags.
module uart_framed #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [15:0]                 in_baud_div,
  input  logic                        in_rx_en,
  input  logic                        in_rx_data,
  input  logic                        in_rx_read,
  output logic [DATA_WIDTH-1:0]       out_rx_data,
  output logic                        out_rx_empty,
  output logic                        out_rx_full,
  output logic [$clog2(FIFO_DEPTH):0] out_rx_count,
  output logic                        out_rx_overrun,
  output logic                        out_rx_frame_err,
  output logic                        out_rx_parity_err,
  input  logic                        in_err_clr,
  input  logic                        in_tx_en,
  input  logic                        in_tx_write,
  input  logic [DATA_WIDTH-1:0]       in_tx_data,
  output logic                        out_tx_full,
  output logic                        out_tx_empty,
  output logic                        out_tx_data,
  output logic                        out_tx_busy,
  output logic                        out_tx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [15:0] div_eff;
  assign div_eff = (in_baud_div < 16'd2) ? 16'd2 : in_baud_div;

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]         rx_count;
  logic                  rx_push_q, rx_pop, rx_push_ok;
  logic [DATA_WIDTH-1:0] rx_shift;

  assign out_rx_empty = (rx_count == '0);
  assign out_rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign out_rx_count = rx_count;
  assign rx_pop       = in_rx_read && !out_rx_empty;
  assign rx_push_ok   = rx_push_q && (!out_rx_full || rx_pop);
  assign out_rx_data  = out_rx_empty ? '0 : rx_mem[rx_rd_ptr];

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + AW'(1);
      rx_count <= rx_count + CW'(rx_push_ok) - CW'(rx_pop);
    end
  end

  always_ff @(posedge in_clk) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0]         tx_count;
  logic                  tx_pop, tx_push;
  logic [DATA_WIDTH-1:0] tx_head;

  assign out_tx_empty = (tx_count == '0);
  assign out_tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_push      = in_tx_write && (!out_tx_full || tx_pop);
  assign tx_head      = tx_mem[tx_rd_ptr];

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge in_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= in_tx_data;
  end

  // ---------------- RX FSM ----------------
  state_t        rx_state, rx_next;
  logic          rx_meta, rx_s;
  logic [15:0]   rx_div, rx_cnt;
  logic [BW-1:0] rx_bit;
  logic          rx_stop_idx, rx_par_bad;
  logic          rx_tick, rx_last_stop, frame_set;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (!in_rx_en) begin
      rx_next = IDLE;
    end else begin
      case (rx_state)
        IDLE:    if (!rx_s) rx_next = START;
        START:   if (rx_tick) rx_next = rx_s ? IDLE : DATA;
        DATA:    if (rx_tick && rx_bit == LAST_BIT) rx_next = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  if (rx_tick) rx_next = STOP;
        STOP:    if (rx_tick && (!rx_s || rx_stop_idx == LAST_STOP)) rx_next = IDLE;
        default: rx_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_tick      = in_rx_en && (rx_state != IDLE) && (rx_cnt == '0);
    rx_last_stop = rx_tick && (rx_state == STOP) && rx_s && (rx_stop_idx == LAST_STOP);
    frame_set    = rx_tick && (rx_state == STOP) && !rx_s;
  end

  // The divisor is re-latched every idle cycle so the frame uses the value seen at its start.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_div      <= 16'd2;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_stop_idx <= 1'b0;
      rx_shift    <= '0;
      rx_par_bad  <= 1'b0;
      rx_push_q   <= 1'b0;
    end else begin
      rx_meta   <= in_rx_data;
      rx_s      <= rx_meta;
      rx_push_q <= rx_last_stop;
      if (rx_state == IDLE) begin
        rx_div      <= div_eff;
        rx_cnt      <= (div_eff >> 1) - 16'd1;
        rx_bit      <= '0;
        rx_stop_idx <= 1'b0;
        rx_par_bad  <= 1'b0;
      end else if (rx_tick) begin
        rx_cnt <= rx_div - 16'd1;
        case (rx_state)
          DATA: begin
            rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
            rx_bit   <= rx_bit + BW'(1);
          end
          PARITY:  rx_par_bad  <= (rx_s != ((^rx_shift) ^ ODD));
          STOP:    rx_stop_idx <= 1'b1;
          default: ;
        endcase
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_rx_overrun    <= 1'b0;
      out_rx_frame_err  <= 1'b0;
      out_rx_parity_err <= 1'b0;
    end else begin
      if (rx_push_q && out_rx_full && !rx_pop) out_rx_overrun <= 1'b1;
      else if (in_err_clr)                     out_rx_overrun <= 1'b0;
      if (frame_set)        out_rx_frame_err <= 1'b1;
      else if (in_err_clr)  out_rx_frame_err <= 1'b0;
      if (rx_push_q && rx_par_bad) out_rx_parity_err <= 1'b1;
      else if (in_err_clr)         out_rx_parity_err <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  state_t                tx_state, tx_next;
  logic [15:0]           tx_div, tx_cnt;
  logic [BW-1:0]         tx_bit;
  logic                  tx_stop_idx, tx_par, tx_tick, tx_end;
  logic [DATA_WIDTH-1:0] tx_shift;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) tx_state <= IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (tx_pop) tx_next = START;
      START:   if (tx_tick) tx_next = DATA;
      DATA:    if (tx_tick && tx_bit == LAST_BIT) tx_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tx_tick) tx_next = STOP;
      STOP:    if (tx_end) tx_next = tx_pop ? START : IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    tx_tick     = (tx_state != IDLE) && (tx_cnt == '0);
    tx_end      = tx_tick && (tx_state == STOP) && (tx_stop_idx == LAST_STOP);
    tx_pop      = in_tx_en && !out_tx_empty && ((tx_state == IDLE) || tx_end);
    out_tx_busy = (tx_state != IDLE);
    out_tx_done = tx_end;
  end

  // The serial line is a register so it only ever changes on a clock edge or reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_tx_data <= 1'b1;
      tx_div      <= 16'd2;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_stop_idx <= 1'b0;
      tx_par      <= 1'b0;
      tx_shift    <= '0;
    end else begin
      if (tx_tick) begin
        tx_cnt <= tx_div - 16'd1;
        case (tx_state)
          START: out_tx_data <= tx_shift[0];
          DATA: begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + BW'(1);
            if (tx_bit == LAST_BIT) out_tx_data <= (PARITY_EN != 0) ? tx_par : 1'b1;
            else                    out_tx_data <= tx_shift[1];
          end
          PARITY:  out_tx_data <= 1'b1;
          STOP:    tx_stop_idx <= 1'b1;
          default: ;
        endcase
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end
      if (tx_pop) begin
        tx_shift    <= tx_head;
        tx_par      <= (^tx_head) ^ ODD;
        tx_div      <= div_eff;
        tx_cnt      <= div_eff - 16'd1;
        tx_bit      <= '0;
        tx_stop_idx <= 1'b0;
        out_tx_data <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_framed.sv
// tb/tb_uart_framed.sv - directed bench for uart_framed (depth 4, even parity, 1 stop bit).
module tb_uart_framed;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud;
  logic        rx_en, tb_rx, loop, rx_read, err_clr, tx_en, tx_write;
  logic [7:0]  tx_wdata;
  logic        rx_line;
  logic [7:0]  rx_data;
  logic        rx_empty, rx_full, overrun, frame_err, parity_err;
  logic [2:0]  rx_count;
  logic        tx_full, tx_empty, tx_line, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rx_line = loop ? tx_line : tb_rx;

  uart_framed #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .in_clk(clk), .in_rst(rst), .in_baud_div(baud),
    .in_rx_en(rx_en), .in_rx_data(rx_line), .in_rx_read(rx_read),
    .out_rx_data(rx_data), .out_rx_empty(rx_empty), .out_rx_full(rx_full),
    .out_rx_count(rx_count), .out_rx_overrun(overrun), .out_rx_frame_err(frame_err),
    .out_rx_parity_err(parity_err), .in_err_clr(err_clr),
    .in_tx_en(tx_en), .in_tx_write(tx_write), .in_tx_data(tx_wdata),
    .out_tx_full(tx_full), .out_tx_empty(tx_empty), .out_tx_data(tx_line),
    .out_tx_busy(tx_busy), .out_tx_done(tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_wdata = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic wait_tx_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input logic par, input logic stp, input int div);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tb_rx = bits[i];
      repeat (div) @(negedge clk);
    end
    tb_rx = 1'b1;
    repeat (3 * div) @(negedge clk);
  endtask

  task automatic rx_pop();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic        ok;
    logic [10:0] a5_bits;
    int          n;
    rst = 1'b1; baud = 16'd4; rx_en = 1'b0; tb_rx = 1'b1; loop = 1'b0;
    rx_read = 1'b0; err_clr = 1'b0; tx_en = 1'b0; tx_write = 1'b0; tx_wdata = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_tx_line", tx_line, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_full", rx_full, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_flags", {overrun, frame_err, parity_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5, div 4: start, 1,0,1,0,0,1,0,1, even parity 0, stop
    a5_bits = 11'b1_0_10100101_0;
    tx_push(8'hA5);
    chk("a5_queued", tx_empty, 0);
    tx_en = 1'b1;
    wait_tx_start(ok);
    chk("a5_start_seen", ok, 1);
    for (int b = 0; b < 11; b++) begin
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("a5_line_b%0d_s%0d", b, s), tx_line, a5_bits[b]);
        chk($sformatf("a5_done_b%0d_s%0d", b, s), tx_done, (b == 10 && s == 3) ? 1 : 0);
        chk($sformatf("a5_busy_b%0d_s%0d", b, s), tx_busy, 1);
        @(negedge clk);
      end
    end
    chk("a5_idle_busy", tx_busy, 0);
    chk("a5_idle_line", tx_line, 1);

    // reset during data bit 3 of 0x35 (bit 3 is 0), second word still queued
    tx_en = 1'b0;
    tx_push(8'h35);
    tx_push(8'h99);
    tx_en = 1'b1;
    wait_tx_start(ok);
    chk("rstmid_start_seen", ok, 1);
    repeat (17) @(negedge clk);
    chk("rstmid_bit3_low", tx_line, 0);
    rst = 1'b1;
    #1;
    chk("rstmid_line", tx_line, 1);
    chk("rstmid_tx_empty", tx_empty, 1);
    chk("rstmid_busy", tx_busy, 0);
    chk("rstmid_done", tx_done, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_line !== 1'b1) n++;
    end
    chk("rstmid_quiet", n, 0);
    tx_en = 1'b0;

    // loopback 0x07, div 8: parity bit 1
    baud = 16'd8; loop = 1'b1; rx_en = 1'b1; tx_en = 1'b1;
    tx_push(8'h07);
    wait_tx_start(ok);
    chk("loop_start_seen", ok, 1);
    repeat (76) @(negedge clk);
    chk("loop_parity_bit", tx_line, 1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx_empty === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("loop_rx_arrived", ok, 1);
    chk("loop_rx_data", rx_data, 8'h07);
    chk("loop_rx_count", rx_count, 1);
    chk("loop_flags", {overrun, frame_err, parity_err}, 0);
    rx_pop();
    chk("loop_rx_drained", rx_empty, 1);
    repeat (20) @(negedge clk);
    loop = 1'b0; tx_en = 1'b0;
    repeat (4) @(negedge clk);

    // stop bit driven low
    baud = 16'd4;
    rx_send(8'h5A, 1'b0, 1'b0, 4);
    chk("ferr_flag", frame_err, 1);
    chk("ferr_rx_empty", rx_empty, 1);
    chk("ferr_no_parity", parity_err, 0);
    clear_errs();
    chk("ferr_cleared", frame_err, 0);

    // wrong parity: word kept, flag set
    rx_send(8'h07, 1'b0, 1'b1, 4);
    chk("perr_flag", parity_err, 1);
    chk("perr_rx_data", rx_data, 8'h07);
    chk("perr_count", rx_count, 1);
    chk("perr_no_frame", frame_err, 0);
    rx_pop();
    clear_errs();
    chk("perr_cleared", parity_err, 0);

    // five words into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'h11 + 8'(i);
      rx_send(d, ^d, 1'b1, 4);
    end
    chk("ovr_count", rx_count, 4);
    chk("ovr_full", rx_full, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_no_parity", parity_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr_read%0d", i), rx_data, 8'h11 + i);
      rx_pop();
    end
    chk("ovr_drained", rx_empty, 1);
    chk("ovr_drained_count", rx_count, 0);
    clear_errs();
    chk("ovr_cleared", overrun, 0);

    // two-clock glitch with div 16
    baud = 16'd16;
    tb_rx = 1'b0;
    repeat (2) @(negedge clk);
    tb_rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_rx_empty", rx_empty, 1);
    chk("glitch_count", rx_count, 0);
    chk("glitch_flags", {overrun, frame_err, parity_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
